muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide sequencer. Drives the shared alu through its ALU_ADD

---
 rtl/muldiv_seq_if.sv | 29 ++
 rtl/muldiv_seq.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response and alu-port bundle for the iterative multiply/divide sequencer.
// The master side is the pipeline (it also hosts the shared alu); the slave side is muldiv_seq.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] alu_add1;
  logic [XLEN-1:0] alu_add2;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] alu_sum;
  logic            alu_carry;

  modport master (
    output start, flush, op, rs1, rs2, alu_sum, alu_carry,
    input  busy, done, result, alu_add1, alu_add2, alu_sel
  );

  modport slave (
    input  start, flush, op, rs1, rs2, alu_sum, alu_carry,
    output busy, done, result, alu_add1, alu_add2, alu_sel
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. Owns no adder: every addition,
// including sign fix-ups, goes through the shared alu's add port.
// Fixed latency: done is high XLEN+4 edges after start is accepted.
module muldiv_seq #(
  parameter int         XLEN    = 32,
  parameter logic [3:0] ALU_ADD = 4'd0
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);
  localparam int              CW  = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      op_reg;
  logic [XLEN-1:0] rs1_reg, rs2_reg;
  // hi: product high half (mul) or partial remainder R (div)
  // lo: product low half (mul) or quotient Q (div)
  // b : |rs2| (mul) or -|rs2| (div)
  logic [XLEN-1:0] hi_reg, lo_reg, b_reg, result_reg;
  logic            fix_carry_reg;
  logic [XLEN-1:0] hi_next, lo_next, b_next, result_next;
  logic            fix_carry_next;

  logic            accept;
  logic            is_div, is_rem, a_neg, b_neg, neg_res, div_zero;
  logic [XLEN-1:0] r_shift;
  logic            q_bit;

  assign accept = (state_reg == S_IDLE) && bus.start && !bus.flush;

  // Operand classification from the latched request
  assign is_div   = op_reg[2];
  assign is_rem   = op_reg[2] & op_reg[1];
  assign a_neg    = rs1_reg[XLEN-1] &
                    ((op_reg == 3'b001) || (op_reg == 3'b010) ||
                     (op_reg == 3'b100) || (op_reg == 3'b110));
  assign b_neg    = rs2_reg[XLEN-1] &
                    ((op_reg == 3'b001) || (op_reg == 3'b100) || (op_reg == 3'b110));
  // Remainder takes the dividend's sign; everything else the product/quotient sign
  assign neg_res  = is_rem ? a_neg : (a_neg ^ b_neg);
  assign div_zero = (rs2_reg == '0);

  // Restoring-divide step: shift next dividend bit into R, trial-add -|divisor|
  assign r_shift  = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
  assign q_bit    = hi_reg[XLEN-1] | bus.alu_carry;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (accept) state_next = S_NEG_A;
      S_NEG_A:  state_next = S_NEG_B;
      S_NEG_B:  state_next = S_ITER;
      S_ITER:   if (cnt_reg == CW'(XLEN-1)) state_next = S_FIX_LO;
      S_FIX_LO: state_next = S_FIX_HI;
      S_FIX_HI: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (bus.flush) state_next = S_IDLE;
  end

  // Outputs: status flags and alu operands; the alu only ever adds,
  // subtraction is done by feeding it an inverted operand plus one
  always_comb begin
    bus.busy     = (state_reg != S_IDLE);
    bus.done     = (state_reg == S_DONE);
    bus.result   = result_reg;
    bus.alu_sel  = ALU_ADD;
    bus.alu_add1 = '0;
    bus.alu_add2 = '0;
    case (state_reg)
      S_NEG_A: begin
        bus.alu_add1 = ~rs1_reg;
        bus.alu_add2 = ONE;
      end
      S_NEG_B: begin
        bus.alu_add1 = ~rs2_reg;
        bus.alu_add2 = ONE;
      end
      S_ITER: begin
        if (is_div) begin
          bus.alu_add1 = r_shift;
          bus.alu_add2 = b_reg;
        end else begin
          // Adding zero on a clear multiplier bit keeps the shift path uniform
          bus.alu_add1 = hi_reg;
          bus.alu_add2 = lo_reg[0] ? b_reg : '0;
        end
      end
      S_FIX_LO: begin
        if (neg_res) begin
          bus.alu_add1 = is_rem ? ~hi_reg : ~lo_reg;
          bus.alu_add2 = ONE;
        end
      end
      S_FIX_HI: begin
        if (!is_div && neg_res) begin
          bus.alu_add1 = ~hi_reg;
          bus.alu_add2 = {{(XLEN-1){1'b0}}, fix_carry_reg};
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath next values, taken from the alu result of the current state
  always_comb begin
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    b_next         = b_reg;
    fix_carry_next = fix_carry_reg;
    result_next    = result_reg;
    case (state_reg)
      S_NEG_A: begin
        lo_next = a_neg ? bus.alu_sum : rs1_reg;
        hi_next = '0;
      end
      S_NEG_B: begin
        if (is_div) b_next = b_neg ? rs2_reg : bus.alu_sum;
        else        b_next = b_neg ? bus.alu_sum : rs2_reg;
      end
      S_ITER: begin
        if (is_div) begin
          hi_next = q_bit ? bus.alu_sum : r_shift;
          lo_next = {lo_reg[XLEN-2:0], q_bit};
        end else begin
          {hi_next, lo_next} = {bus.alu_carry, bus.alu_sum, lo_reg[XLEN-1:1]};
        end
      end
      S_FIX_LO: begin
        fix_carry_next = bus.alu_carry;
        if (neg_res) begin
          if (is_rem) hi_next = bus.alu_sum;
          else        lo_next = bus.alu_sum;
        end
      end
      S_FIX_HI: begin
        if (!is_div && neg_res) hi_next = bus.alu_sum;
        // Result is committed on the way into DONE unless the op is being killed
        if (!bus.flush) begin
          case (op_reg)
            3'b000:  result_next = lo_next;
            3'b001,
            3'b010,
            3'b011:  result_next = hi_next;
            3'b100,
            3'b101:  result_next = div_zero ? '1 : lo_next;
            default: result_next = div_zero ? rs1_reg : hi_next;
          endcase
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers, operand latch and iteration counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg        <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      b_reg         <= '0;
      fix_carry_reg <= 1'b0;
      result_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      if (accept) begin
        op_reg  <= bus.op;
        rs1_reg <= bus.rs1;
        rs2_reg <= bus.rs2;
      end
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      b_reg         <= b_next;
      fix_carry_reg <= fix_carry_next;
      result_reg    <= result_next;
      if (state_reg == S_NEG_B)     cnt_reg <= '0;
      else if (state_reg == S_ITER) cnt_reg <= cnt_reg + CW'(1);
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, multi-cycle corner
// sequences (flush, ignored start, mid-op reset) and randomized ops against a
// plain-arithmetic RV32M reference.
module tb_muldiv_seq;
  localparam int XLEN = 32;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam int LATENCY = XLEN + 4;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  muldiv_seq_if #(.XLEN(XLEN)) bus();

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared alu's add port
  always_comb {bus.alu_carry, bus.alu_sum} = {1'b0, bus.alu_add1} + {1'b0, bus.alu_add2};

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p  = '0;
    case (op)
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      OP_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      OP_DIV:    begin if (b == 0) return '1; p = 64'(sa / sb); return p[31:0]; end
      OP_DIVU:   begin if (b == 0) return '1; return a / b; end
      OP_REM:    begin if (b == 0) return a;  p = 64'(sa % sb); return p[31:0]; end
      default:   begin if (b == 0) return a;  return a % b; end
    endcase
  endfunction

  // Issue one op and wait (bounded) for done. lat counts edges after the
  // accepting edge; busy_cnt counts busy cycles before done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cnt,
                        output bit timeout);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    @(negedge clk);
    bus.start = 1'b0;
    // Scramble the operand inputs: the op must use the latched copies
    bus.op    = 3'($urandom);
    bus.rs1   = $urandom;
    bus.rs2   = $urandom;
    lat       = 0;
    busy_cnt  = 0;
    timeout   = 1'b0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!bus.done) timeout = 1'b1;
    res = bus.result;
  endtask

  task automatic check_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
    logic [31:0] res;
    int          lat, busy_cnt;
    bit          timeout;
    run_op(op, a, b, res, lat, busy_cnt, timeout);
    $display("%-10s op=%0d rs1=%h rs2=%h result=%h expected=%h latency=%0d",
             name, op, a, b, res, exp, lat);
    check({name, "_timeout"}, 32'(timeout), 32'd0);
    check(name, res, exp);
    check({name, "_latency"}, 32'(lat), 32'(LATENCY));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(LATENCY));
    check({name, "_done_alu_idle"}, bus.alu_add1 | bus.alu_add2, 32'd0);
    @(negedge clk);
    check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_idle_done"}, 32'(bus.done), 32'd0);
    check({name, "_held"}, bus.result, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev, a, b;
    logic [2:0]  op;
    int          lat, dones;

    vecs[0]  = '{OP_MUL,    32'd7,          32'd6,          32'd42,         "mul_7x6"};
    vecs[1]  = '{OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   "mulh_m1"};
    vecs[2]  = '{OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   "mulhsu_m1"};
    vecs[3]  = '{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   "mulhu_max"};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   "div_m7_2"};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   "rem_m7_2"};
    vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,          32'd14,         "divu_100_7"};
    vecs[7]  = '{OP_REMU,   32'd100,        32'd7,          32'd2,          "remu_100_7"};
    vecs[8]  = '{OP_DIV,    32'd5,          32'd0,          32'hFFFFFFFF,   "div_by0"};
    vecs[9]  = '{OP_REM,    32'd5,          32'd0,          32'd5,          "rem_by0"};
    vecs[10] = '{OP_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   "div_ovf"};
    vecs[11] = '{OP_REM,    32'h80000000,   32'hFFFFFFFF,   32'h00000000,   "rem_ovf"};
    vecs[12] = '{OP_MULH,   32'h80000000,   32'h80000000,   32'h40000000,   "mulh_min"};
    vecs[13] = '{OP_REM,    32'h80000001,   32'h80000000,   32'h80000001,   "rem_min"};
    vecs[14] = '{OP_DIV,    32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   "div_7_m2"};
    vecs[15] = '{OP_REMU,   32'h12345678,   32'd0,          32'h12345678,   "remu_by0"};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.rs1   = '0;
    bus.rs2   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(bus.busy), 32'd0);
    check("reset_done",   32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_add1",   bus.alu_add1, 32'd0);
    check("reset_add2",   bus.alu_add2, 32'd0);
    check("reset_sel",    32'(bus.alu_sel), 32'd0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      check_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    end

    // Flush during ITER (count 10): no done, result untouched, then a clean op
    prev = bus.result;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.rs1 = 32'h0001_2345; bus.rs2 = 32'h0000_6789;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    check("flush_busy_before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    $display("flush      at ITER count 10 busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
    check("flush_busy",   32'(bus.busy), 32'd0);
    check("flush_done",   32'(bus.done), 32'd0);
    check("flush_result", bus.result, prev);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);
    check_op(OP_MUL, 32'd3, 32'd3, 32'd9, "mul_after_flush");

    // Flush and start together in IDLE: start is dropped
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MUL; bus.rs1 = 32'd2; bus.rs2 = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    $display("flush+start in IDLE busy=%0d", bus.busy);
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("flush_start_busy2", 32'(bus.busy), 32'd0);

    // Start pulses while busy and during DONE are ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      if (lat == 5) begin
        bus.start = 1'b1; bus.op = OP_MUL; bus.rs1 = 32'd3; bus.rs2 = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check("ignore_latency", 32'(lat), 32'(LATENCY));
    check("ignore_result", bus.result, 32'd14);
    bus.start = 1'b1; bus.op = OP_MUL; bus.rs1 = 32'd5; bus.rs2 = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    $display("ignore     start during busy/DONE result=%h busy=%0d", bus.result, bus.busy);
    check("ignore_done_start_busy", 32'(bus.busy), 32'd0);
    check("ignore_result_held", bus.result, 32'd14);

    // Reset in the middle of an op
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.rs1 = 32'hDEAD_BEEF; bus.rs2 = 32'd13;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    $display("reset      mid-op busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
    check("midrst_busy",   32'(bus.busy), 32'd0);
    check("midrst_done",   32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_add1",   bus.alu_add1, 32'd0);
    check("midrst_add2",   bus.alu_add2, 32'd0);
    rst_n = 1'b1;
    check_op(OP_MULHU, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0000_0DEA, "mulhu_after_rst");

    // Randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      check_op(op, a, b, model(op, a, b), "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
